// File: rtl/pipe_hazard_unit.sv
// Hazard control for a 5-stage in-order pipeline: load-use stalls, branch flushes, EX forwarding.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module pipe_hazard_unit #(
   parameter int REG_W    = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_we,
   input  logic             id_is_load,
   input  logic             ex_branch_taken,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             bubble_idex,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic [1:0]       fwd1_sel,
   output logic [1:0]       fwd2_sel,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             we;
      logic             is_load;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic             rs1_used;
      logic             rs2_used;
   } entry_t;

   // MEM and WB only ever act as forwarding sources, so they carry just the destination fields.
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             we;
   } dest_t;

   localparam logic [1:0] FWD_IDEX = 2'b00;
   localparam logic [1:0] FWD_MEM  = 2'b01;
   localparam logic [1:0] FWD_WB   = 2'b10;

   entry_t     id_entry;
   entry_t     ex_q;
   dest_t      mem_q;
   dest_t      wb_q;
   logic [1:0] stall_left_q;
   logic       hazard;
   logic       stall;

   function automatic logic [1:0] pick_fwd(input logic [REG_W-1:0] src, input logic used,
                                           input dest_t mem, input dest_t wb);
      logic mem_hit;
      logic wb_hit;
      mem_hit = used && mem.valid && mem.we && (mem.rd != '0) && (mem.rd == src);
      wb_hit  = used && wb.valid && wb.we && (wb.rd != '0) && (wb.rd == src);
      if (mem_hit)     return FWD_MEM;
      else if (wb_hit) return FWD_WB;
      else             return FWD_IDEX;
   endfunction

   assign id_entry = '{valid: id_valid, rd: id_rd, we: id_we, is_load: id_is_load,
                       rs1: id_rs1, rs2: id_rs2, rs1_used: id_rs1_used, rs2_used: id_rs2_used};

   assign hazard = id_valid && ex_q.valid && ex_q.is_load && (ex_q.rd != '0) &&
                   ((id_rs1_used && (id_rs1 == ex_q.rd)) || (id_rs2_used && (id_rs2 == ex_q.rd)));

   // A taken branch squashes the stalled instruction, so it overrides any stall in progress.
   assign stall = !ex_branch_taken && (hazard || (stall_left_q != 2'd0));

   assign stall_pc    = stall;
   assign stall_ifid  = stall;
   assign bubble_idex = stall;
   assign flush_ifid  = ex_branch_taken;
   assign flush_idex  = ex_branch_taken;

   assign fwd1_sel = pick_fwd(ex_q.rs1, ex_q.rs1_used, mem_q, wb_q);
   assign fwd2_sel = pick_fwd(ex_q.rs2, ex_q.rs2_used, mem_q, wb_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q         <= '0;
         mem_q        <= '0;
         wb_q         <= '0;
         stall_left_q <= 2'd0;
      end else begin
         // NOTE: non-blocking updates let EX->MEM->WB shift in one edge using the old values.
         ex_q  <= (stall || ex_branch_taken) ? entry_t'('0) : id_entry;
         mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, we: ex_q.we};
         wb_q  <= mem_q;
         if (ex_branch_taken)
            stall_left_q <= 2'd0;
         else if (stall_left_q != 2'd0)
            stall_left_q <= stall_left_q - 2'd1;
         else if (hazard)
            stall_left_q <= 2'(LOAD_LAT - 1);
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // Counters saturate at all-ones so long runs never wrap back to small values.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (ex_branch_taken && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench: three pipe_hazard_unit instances (LOAD_LAT 1/3/2, CNT_W 16/16/4) share
// stimulus and are compared every cycle against an abstract pipeline model.
module tb_pipe_hazard_unit;
   localparam int N = 3;

`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, ex_branch_taken;
   logic [4:0] id_rs1, id_rs2, id_rd;

   logic [4:0]  ctl_o  [N];
   logic [1:0]  fwd1_o [N];
   logic [1:0]  fwd2_o [N];
   logic [31:0] scnt_o [N];
   logic [31:0] fcnt_o [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 2;
      localparam int CW  = (g == 2) ? 4 : 16;
      logic [CW-1:0] sc, fc;
      logic          sp, si, bi, fi, fe;
      logic [1:0]    f1, f2;

      pipe_hazard_unit #(.REG_W(5), .LOAD_LAT(LAT), .CNT_W(CW)) u_dut (
         .clk(clk), .rst(rst),
         .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
         .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
         .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
         .ex_branch_taken(ex_branch_taken),
         .stall_pc(sp), .stall_ifid(si), .bubble_idex(bi),
         .flush_ifid(fi), .flush_idex(fe),
         .fwd1_sel(f1), .fwd2_sel(f2),
         .stall_cnt(sc), .flush_cnt(fc)
      );

      assign ctl_o[g]  = {sp, si, bi, fi, fe};
      assign fwd1_o[g] = f1;
      assign fwd2_o[g] = f2;
      assign scnt_o[g] = 32'(sc);
      assign fcnt_o[g] = 32'(fc);
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: each instance has its own instruction pipeline (0=EX,1=MEM,2=WB),
   // the last cycle number of its current stall window, and plain integer event counts.
   typedef struct packed {
      bit valid;
      int rd;
      bit we;
      bit is_load;
      int rs1;
      int rs2;
      bit rs1_used;
      bit rs2_used;
   } instr_t;

   instr_t m_pipe [N][3];
   int     m_until [N];
   int     m_scnt [N];
   int     m_fcnt [N];
   int     cyc = 0;

   logic [4:0]  snap_ctl  [N];
   logic [1:0]  snap_fwd1 [N];
   logic [1:0]  snap_fwd2 [N];
   logic [31:0] snap_scnt [N];
   logic [31:0] snap_fcnt [N];

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 3 : 2;
   endfunction

   function automatic int cmax_of(input int k);
      return (k == 2) ? 15 : 65535;
   endfunction

   function automatic bit m_hazard(input int k);
      instr_t e;
      e = m_pipe[k][0];
      return id_valid && e.valid && e.is_load && (e.rd != 0) &&
             ((id_rs1_used && (int'(id_rs1) == e.rd)) || (id_rs2_used && (int'(id_rs2) == e.rd)));
   endfunction

   // Nearest older producer of src wins; stage index 1 -> code 01, index 2 -> code 10.
   function automatic logic [1:0] m_fwd(input int k, input int src, input bit used);
      for (int s = 1; s <= 2; s++)
         if (used && src != 0 && m_pipe[k][s].valid && m_pipe[k][s].we && m_pipe[k][s].rd == src)
            return 2'(s);
      return 2'b00;
   endfunction

   function automatic instr_t id_instr();
      instr_t e;
      e.valid = id_valid;      e.rd = int'(id_rd);    e.we = id_we;  e.is_load = id_is_load;
      e.rs1 = int'(id_rs1);    e.rs2 = int'(id_rs2);
      e.rs1_used = id_rs1_used; e.rs2_used = id_rs2_used;
      return e;
   endfunction

   task automatic cycle(input bit chk);
      bit hz [N];
      bit st [N];
      logic [31:0] exp_ctl;
      #1;
      for (int k = 0; k < N; k++) begin
         hz[k] = m_hazard(k);
         st[k] = !ex_branch_taken && (hz[k] || cyc <= m_until[k]);
         snap_ctl[k]  = ctl_o[k];
         snap_fwd1[k] = fwd1_o[k];
         snap_fwd2[k] = fwd2_o[k];
         snap_scnt[k] = scnt_o[k];
         snap_fcnt[k] = fcnt_o[k];
         if (chk) begin
            exp_ctl = {27'd0, st[k], st[k], st[k], ex_branch_taken, ex_branch_taken};
            check($sformatf("ctl[%0d]@%0d", k, cyc), 32'(ctl_o[k]), exp_ctl);
            check($sformatf("fwd1[%0d]@%0d", k, cyc), 32'(fwd1_o[k]),
                  32'(m_fwd(k, m_pipe[k][0].rs1, m_pipe[k][0].rs1_used)));
            check($sformatf("fwd2[%0d]@%0d", k, cyc), 32'(fwd2_o[k]),
                  32'(m_fwd(k, m_pipe[k][0].rs2, m_pipe[k][0].rs2_used)));
            check($sformatf("stall_cnt[%0d]@%0d", k, cyc), scnt_o[k], PERF ? 32'(m_scnt[k]) : 32'd0);
            check($sformatf("flush_cnt[%0d]@%0d", k, cyc), fcnt_o[k], PERF ? 32'(m_fcnt[k]) : 32'd0);
         end
      end
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
         if (rst) begin
            for (int s = 0; s < 3; s++) m_pipe[k][s] = '0;
            m_until[k] = -1;
            m_scnt[k]  = 0;
            m_fcnt[k]  = 0;
         end else begin
            if (ex_branch_taken)  m_until[k] = -1;
            else if (hz[k])       m_until[k] = cyc + lat_of(k) - 1;
            m_pipe[k][2] = m_pipe[k][1];
            m_pipe[k][1] = m_pipe[k][0];
            m_pipe[k][0] = (st[k] || ex_branch_taken) ? instr_t'('0) : id_instr();
            m_scnt[k] = (m_scnt[k] + int'(st[k]) > cmax_of(k)) ? cmax_of(k) : m_scnt[k] + int'(st[k]);
            m_fcnt[k] = (m_fcnt[k] + int'(ex_branch_taken) > cmax_of(k)) ? cmax_of(k)
                                                                       : m_fcnt[k] + int'(ex_branch_taken);
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit we, input bit ld);
      id_valid = v;        id_rs1 = 5'(rs1);    id_rs1_used = u1;
      id_rs2 = 5'(rs2);    id_rs2_used = u2;    id_rd = 5'(rd);
      id_we = we;          id_is_load = ld;
   endtask

   task automatic nop_cycles(input int n);
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) cycle(1);
   endtask

   int runs [N];

   initial begin
      for (int k = 0; k < N; k++) m_until[k] = -1;
      rst = 1'b1;
      ex_branch_taken = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      cycle(0);
      cycle(1);
      rst = 1'b0;
      cycle(1);
      check("post_reset_ctl", 32'(snap_ctl[0]), 32'd0);
      check("post_reset_fwd", 32'({snap_fwd1[1], snap_fwd2[1]}), 32'd0);

      // lw x5 then add x6,x5,x7 held in ID: stall length equals LOAD_LAT per instance
      set_id(1, 0, 0, 0, 0, 5, 1, 1);
      cycle(1);
      set_id(1, 5, 1, 7, 1, 6, 1, 0);
      for (int k = 0; k < N; k++) runs[k] = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(1);
         for (int k = 0; k < N; k++) runs[k] += int'(snap_ctl[k][4]);
         if (i == 0) check("load_use_bubble", 32'(snap_ctl[0]), 32'b11100);
         if (i == 2) check("load_use_fwd1_wb", 32'(snap_fwd1[0]), 32'd2);
      end
      nop_cycles(1);
      check("stall_len_lat1", runs[0], 1);
      check("stall_len_lat3", runs[1], 3);
      check("stall_len_lat2", runs[2], 2);
      check("stall_cnt_lat3", snap_scnt[1], PERF ? 32'd3 : 32'd0);
      nop_cycles(3);

      // two add x5 producers in MEM/WB, EX reads x5 as rs2 -> MEM wins; x0 never forwards
      set_id(1, 1, 1, 2, 1, 5, 1, 0); cycle(1);
      set_id(1, 1, 1, 2, 1, 5, 1, 0); cycle(1);
      set_id(1, 3, 1, 5, 1, 9, 1, 0); cycle(1);
      nop_cycles(1);
      check("fwd2_mem_priority", 32'(snap_fwd2[0]), 32'd1);
      check("fwd1_no_match", 32'(snap_fwd1[0]), 32'd0);
      set_id(1, 1, 1, 2, 1, 0, 1, 0); cycle(1);
      set_id(1, 1, 1, 2, 1, 0, 1, 0); cycle(1);
      set_id(1, 3, 1, 0, 1, 9, 1, 0); cycle(1);
      nop_cycles(1);
      check("fwd2_x0", 32'(snap_fwd2[2]), 32'd0);
      nop_cycles(2);

      // taken branch coinciding with a load-use hazard: flush wins, no stall afterwards
      set_id(1, 0, 0, 0, 0, 5, 1, 1); cycle(1);
      set_id(1, 5, 1, 7, 1, 6, 1, 0);
      ex_branch_taken = 1'b1;
      cycle(1);
      check("flush_over_stall", 32'(snap_ctl[1]), 32'b00011);
      ex_branch_taken = 1'b0;
      nop_cycles(1);
      check("after_flush_ctl", 32'(snap_ctl[1]), 32'd0);
      check("flush_cnt_one", snap_fcnt[1], PERF ? 32'd1 : 32'd0);
      nop_cycles(2);

      // reset in the second cycle of a LOAD_LAT=3 stall aborts it
      set_id(1, 0, 0, 0, 0, 5, 1, 1); cycle(1);
      set_id(1, 0, 0, 5, 1, 6, 1, 0); cycle(1);
      rst = 1'b1;
      cycle(1);
      rst = 1'b0;
      nop_cycles(1);
      check("rst_mid_stall_ctl", 32'(snap_ctl[1]), 32'd0);
      check("rst_mid_stall_scnt", snap_scnt[1], 32'd0);
      check("rst_mid_stall_fcnt", snap_fcnt[1], 32'd0);

      // back-to-back dependent loads keep the CNT_W=4 instance stalling well past saturation
      set_id(1, 1, 1, 0, 0, 1, 1, 1);
      for (int i = 0; i < 40; i++) cycle(1);
      nop_cycles(1);
      check("stall_cnt_saturate", snap_scnt[2], PERF ? 32'd15 : 32'd0);
      nop_cycles(3);

      // randomized traffic on a small register set for dense hazards and forwards
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         set_id($urandom_range(0, 5) != 0,
                $urandom_range(0, 3), $urandom_range(0, 1) != 0,
                $urandom_range(0, 3), $urandom_range(0, 1) != 0,
                $urandom_range(0, 3), $urandom_range(0, 1) != 0, $urandom_range(0, 2) == 0);
         cycle(1);
      end
      rst = 1'b0;
      ex_branch_taken = 1'b0;
      nop_cycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, legal 1..3, load-use stall cycles.
REQ-003 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 id_valid  input  1  ID stage holds a real instruction.
REQ-007 id_rs1, id_rs2  input  REG_W each  ID source indices.
REQ-008 id_rs1_used, id_rs2_used  input  1 each  source actually read.
REQ-009 id_rd  input  REG_W  ID destination index.
REQ-010 id_we, id_is_load  input  1 each  ID writes register / is a load.
REQ-011 ex_branch_taken  input  1  EX resolved a taken branch or jump.
REQ-012 stall_pc, stall_ifid  output  1 each  hold PC / IF-ID register.
REQ-013 bubble_idex  output  1  load NOP control into ID-EX.
REQ-014 flush_ifid, flush_idex  output  1 each  squash wrong-path instructions.
REQ-015 fwd1_sel, fwd2_sel  output  2 each  EX operand source: 00 ID-EX data, 01 MEM result, 10 WB data.
REQ-016 stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-017 SHALL keep a shadow pipeline of three entries (EX, MEM, WB), each {valid, rd, we, is_load, rs1, rs2, rs1_used, rs2_used}, advancing ID->EX->MEM->WB every cycle.
REQ-018 When bubble_idex or flush_idex is 1, the EX entry SHALL load invalid instead of ID fields; MEM and WB SHALL always advance.
REQ-019 fwd1_sel SHALL be 01 if MEM valid, we, rd!=0, rd==EX.rs1 and EX.rs1_used; else 10 for the same WB match; else 00; MEM has priority; fwd2_sel identical on rs2.
REQ-020 Load-use hazard SHALL be: id_valid, EX valid, EX.is_load, EX.rd!=0, and (id_rs1_used and id_rs1==EX.rd, or id_rs2_used and id_rs2==EX.rd).
REQ-021 On hazard detection, stall_pc, stall_ifid and bubble_idex SHALL assert combinationally that cycle and a down-counter SHALL load LOAD_LAT-1.
REQ-022 While the counter is nonzero, stall outputs SHALL stay asserted and the counter SHALL decrement once per cycle; total stall length is exactly LOAD_LAT cycles.
REQ-023 ex_branch_taken SHALL assert flush_ifid and flush_idex combinationally for that cycle only.
REQ-024 Flush SHALL dominate: when ex_branch_taken and a hazard or stall coincide, stall_pc, stall_ifid and bubble_idex SHALL be 0 and the stall counter SHALL clear to 0.
REQ-025 Register index 0 SHALL never cause forwarding or stall.
REQ-026 stall_cnt SHALL increment by 1 per cycle with stall_pc=1, and flush_cnt by 1 per cycle with ex_branch_taken=1; both saturate at all-ones, no wrap.

Reset
REQ-027 With rst=1 at a rising edge, all shadow entries SHALL become invalid, the stall counter 0, and stall_cnt and flush_cnt 0.
REQ-028 After reset, stall_pc, stall_ifid, bubble_idex, flush_ifid and flush_idex SHALL be 0 and fwd1_sel and fwd2_sel SHALL be 00 until new instructions enter.
REQ-029 Reset asserted mid-stall SHALL abort the stall; the next cycle SHALL show no stall.

Configuration
REQ-030 Macro HAZARD_PERF_EN: when defined, stall_cnt and flush_cnt SHALL operate per REQ-026.
REQ-031 When HAZARD_PERF_EN is not defined, stall_cnt and flush_cnt SHALL be constant 0 and no counter flops SHALL be synthesised; all other behaviour SHALL be unchanged.

Verification
REQ-032 Directed: lw x5 into EX, ID add x6,x5,x7 -> stall 1 cycle, one bubble, then fwd1_sel=10 in EX.
REQ-033 Directed: LOAD_LAT=3 load-use -> stall_pc high exactly 3 cycles; stall_cnt=3 with HAZARD_PERF_EN.
REQ-034 Directed: add x5 in MEM and add x5 in WB, EX reads x5 as rs2 -> fwd2_sel=01; rd=x0 in both -> 00.
REQ-035 Directed: ex_branch_taken in the same cycle as a load-use hazard -> flush_ifid=flush_idex=1, stall_pc=0, counter cleared; flush_cnt=1.
REQ-036 Directed: rst during the second cycle of a LOAD_LAT=3 stall -> next cycle all outputs 0 and counters 0.
REQ-037 Directed: CNT_W=4, 20 consecutive stall cycles -> stall_cnt holds 15.
